// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: VGA line constants, default bus
// widths and the read-pipeline tag that routes returning RAM data.
package vram_arbiter_pkg;

  // Vertical timing of the 640x480 VGA frame (lines).
  localparam int VGA_VD     = 480;
  localparam int VGA_VTOTAL = 525;

  // Default memory geometry.
  localparam int DEF_AW = 16;
  localparam int DEF_DW = 8;

  // Owner of the read currently on the RAM command port. A write or an
  // idle clock leaves the tag at TAG_IDLE so nothing is returned for it.
  typedef enum logic [1:0] {
    TAG_IDLE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_REQ0 = 2'd2,
    TAG_REQ1 = 2'd3
  } rd_tag_e;

  // Tag for a read issued on behalf of requester idx.
  function automatic rd_tag_e req_tag(input logic idx);
    return idx ? TAG_REQ1 : TAG_REQ0;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its clients (display fetch and two
// game-logic requesters) and the single-port synchronous RAM.
//
// Handshake: the display fetch is a one-clock strobe (disp_req) that is
// always served, with disp_rvalid two clocks later. A requester raises
// req[i] with we/addr/wdata stable and holds them until it sees ack[i]
// (one-clock pulse, same clock the command is on mem_*); it must drop or
// renew req[i] in the clock after ack. A read returns rdata with rvalid[i]
// exactly one clock after ack[i]; a write returns nothing.
interface vram_arbiter_if
  import vram_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  // Display fetch port
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;

  // Game-logic requester ports
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;
  logic [1:0]    rvalid;

  // RAM command / return port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  disp_req, disp_addr,
    output disp_rdata, disp_rvalid,
    input  req, we, addr0, addr1, wdata0, wdata1,
    output ack, rdata, rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Client / RAM side
  modport master (
    output disp_req, disp_addr,
    input  disp_rdata, disp_rvalid,
    output req, we, addr0, addr1, wdata0, wdata1,
    input  ack, rdata, rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/vram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. ptr names the requester that currently has
// priority; after a grant the other requester gets priority. Requesters
// that are not eligible are simply skipped and the pointer does not move.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] elig,
  output logic [1:0] grant,
  output logic       ptr
);

  // Pick the priority requester if eligible, otherwise the other one.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (ptr == 1'b0) begin
        if (elig[0])      grant = 2'b01;
        else if (elig[1]) grant = 2'b10;
      end else begin
        if (elig[1])      grant = 2'b10;
        else if (elig[0]) grant = 2'b01;
      end
    end
  end

  // The served requester drops to lowest priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (grant[0]) begin
      ptr <= 1'b1;
    end else if (grant[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port synchronous RAM between the VGA
// display fetch (absolute priority, never stalled) and two game-logic
// requesters served round-robin. Writes from the game logic can be held
// back to vertical blanking to avoid tearing. Every RAM command is
// registered; read data is routed back by a one-entry tag pipeline.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int VD          = VGA_VD,
  parameter int VBLANK_ONLY = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [9:0]     pixel_y,
  output logic           frame_start,
  vram_arbiter_if.slave  bus,
  output logic           dbg_rr_ptr,
  output rd_tag_e        dbg_rd_tag
);

  localparam logic [9:0] VD_Y   = 10'(VD);
  localparam logic [9:0] LAST_Y = 10'(VGA_VTOTAL - 1);

  logic          write_ok;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic          rr_ptr;

  logic          cmd_en;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  rd_tag_e       cmd_tag;

  rd_tag_e       rd_tag;
  logic [9:0]    prev_y;

  // Game writes open only in vertical blanking unless the gate is disabled.
  assign write_ok = (VBLANK_ONLY == 0) || (pixel_y >= VD_Y);

  // A requester whose ack is high this clock still shows the old req, so it
  // is masked out to avoid issuing the same access twice.
  assign elig[0] = bus.req[0] & ~bus.ack[0] & (~bus.we[0] | write_ok);
  assign elig[1] = bus.req[1] & ~bus.ack[1] & (~bus.we[1] | write_ok);

  // The display slot pre-empts the requesters entirely.
  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .enable (~bus.disp_req),
    .elig   (elig),
    .grant  (grant),
    .ptr    (rr_ptr)
  );

  // Select the command for the next RAM clock from the granted source.
  always_comb begin
    cmd_en    = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = bus.mem_addr;
    cmd_wdata = bus.mem_wdata;
    cmd_tag   = TAG_IDLE;
    if (bus.disp_req) begin
      cmd_en   = 1'b1;
      cmd_addr = bus.disp_addr;
      cmd_tag  = TAG_DISP;
    end else if (grant[0]) begin
      cmd_en    = 1'b1;
      cmd_we    = bus.we[0];
      cmd_addr  = bus.addr0;
      cmd_wdata = bus.wdata0;
      cmd_tag   = bus.we[0] ? TAG_IDLE : req_tag(1'b0);
    end else if (grant[1]) begin
      cmd_en    = 1'b1;
      cmd_we    = bus.we[1];
      cmd_addr  = bus.addr1;
      cmd_wdata = bus.wdata1;
      cmd_tag   = bus.we[1] ? TAG_IDLE : req_tag(1'b1);
    end
  end

  // Register the RAM command and ack; address/data/we hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.ack       <= 2'b00;
    end else begin
      bus.mem_en <= cmd_en;
      bus.ack    <= grant;
      if (cmd_en) begin
        bus.mem_we    <= cmd_we;
        bus.mem_addr  <= cmd_addr;
        bus.mem_wdata <= cmd_wdata;
      end
    end
  end

  // Track the owner of the read on mem_* and strobe its valid when the RAM
  // returns data one clock later; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_tag          <= TAG_IDLE;
      bus.rvalid      <= 2'b00;
      bus.disp_rvalid <= 1'b0;
    end else begin
      rd_tag          <= cmd_tag;
      bus.rvalid      <= {rd_tag == TAG_REQ1, rd_tag == TAG_REQ0};
      bus.disp_rvalid <= (rd_tag == TAG_DISP);
    end
  end

  // Pulse frame_start for one clock when the line counter wraps to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_y      <= '0;
      frame_start <= 1'b0;
    end else begin
      prev_y      <= pixel_y;
      frame_start <= (prev_y == LAST_Y) && (pixel_y == 10'd0);
    end
  end

  // RAM data goes to both consumers; the valid strobes say who owns it.
  assign bus.rdata      = bus.mem_rdata;
  assign bus.disp_rdata = bus.mem_rdata;

  assign dbg_rr_ptr = rr_ptr;
  assign dbg_rd_tag = rd_tag;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model of the arbitration
// rules and a shadow copy of memory.
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] pixel_y = 10'd0;
  logic       frame_start;
  logic       dbg_rr_ptr;
  rd_tag_e    dbg_rd_tag;

  always #5 clk = ~clk;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_y     (pixel_y),
    .frame_start (frame_start),
    .bus         (bus),
    .dbg_rr_ptr  (dbg_rr_ptr),
    .dbg_rd_tag  (dbg_rd_tag)
  );

  // ---------------- RAM model (environment) ----------------
  logic [DW-1:0] ram [0:255];

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 7 + 3) ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] shadow [0:255];
  int            last_served;
  logic [1:0]    e_ack;
  logic          e_en, e_we, e_wd_known, e_fs;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  rd_tag_e       e_kind, r_kind;
  logic [9:0]    prev_y;
  bit            hold_mode = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_served = 1;           // requester 0 has priority after reset
    e_ack = 2'b00; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_wd_known = 1'b1; e_kind = TAG_IDLE; r_kind = TAG_IDLE;
    e_fs = 1'b0; prev_y = 10'd0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
  endtask

  // Predict what the DUT shows next clock from the inputs now applied.
  task automatic predict();
    logic [1:0]    elig, n_ack;
    logic          n_en, w;
    rd_tag_e       n_kind, old_kind;
    int            win;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (reset) begin
      model_reset();
      return;
    end
    old_kind = e_kind;
    e_fs   = (prev_y == 10'd524) && (pixel_y == 10'd0);
    prev_y = pixel_y;
    n_ack = 2'b00; n_en = 1'b0; n_kind = TAG_IDLE;
    if (bus.disp_req) begin
      n_en = 1'b1; e_we = 1'b0; e_addr = bus.disp_addr; e_wd_known = 1'b0;
      n_kind = TAG_DISP;
      exp_q.push_back(shadow[bus.disp_addr[7:0]]);
    end else begin
      for (int i = 0; i < 2; i++)
        elig[i] = bus.req[i] && !e_ack[i] && (!bus.we[i] || pixel_y >= 10'd480);
      win = -1;
      if (elig == 2'b11)  win = 1 - last_served;
      else if (elig[0])   win = 0;
      else if (elig[1])   win = 1;
      if (win >= 0) begin
        a = (win == 1) ? bus.addr1 : bus.addr0;
        d = (win == 1) ? bus.wdata1 : bus.wdata0;
        w = bus.we[win];
        last_served = win;
        n_ack[win] = 1'b1;
        n_en = 1'b1; e_we = w; e_addr = a;
        if (w) begin
          e_wdata = d; e_wd_known = 1'b1; shadow[a[7:0]] = d;
        end else begin
          e_wd_known = 1'b0;
          n_kind = (win == 1) ? TAG_REQ1 : TAG_REQ0;
          exp_q.push_back(shadow[a[7:0]]);
        end
      end
    end
    e_ack = n_ack; e_en = n_en; e_kind = n_kind; r_kind = old_kind;
  endtask

  task automatic check_cycle();
    logic [DW-1:0] want;
    check_eq("ack",         32'(bus.ack),         32'(e_ack));
    check_eq("mem_en",      32'(bus.mem_en),      32'(e_en));
    check_eq("mem_we",      32'(bus.mem_we),      32'(e_we));
    check_eq("mem_addr",    32'(bus.mem_addr),    32'(e_addr));
    if (e_wd_known) check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
    check_eq("rvalid",      32'(bus.rvalid),      {30'd0, r_kind == TAG_REQ1, r_kind == TAG_REQ0});
    check_eq("disp_rvalid", 32'(bus.disp_rvalid), 32'(r_kind == TAG_DISP));
    if (r_kind != TAG_IDLE) begin
      check_eq("rd_queue", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        if (r_kind == TAG_DISP) check_eq("disp_rdata", 32'(bus.disp_rdata), 32'(want));
        else                    check_eq("rdata",      32'(bus.rdata),      32'(want));
      end
    end
    check_eq("frame_start", 32'(frame_start), 32'(e_fs));
    check_eq("rr_ptr",      32'(dbg_rr_ptr),  32'(last_served == 0));
    check_eq("rd_tag",      32'(dbg_rd_tag),  32'(e_kind));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    predict();
    @(negedge clk);
    check_cycle();
    if (!hold_mode) begin
      for (int i = 0; i < 2; i++) if (bus.ack[i]) bus.req[i] = 1'b0;
    end
    bus.disp_req = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.req = 2'b00; bus.we = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    hold_mode = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic raise_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we[i] = w;
    if (i == 0) begin bus.addr0 = a; bus.wdata0 = d; end
    else        begin bus.addr1 = a; bus.wdata1 = d; end
    bus.req[i] = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [9:0] ys [7];
  int         cnt;
  logic       seen;

  initial begin
    ys = '{10'd100, 10'd300, 10'd479, 10'd480, 10'd500, 10'd524, 10'd0};
    clear_inputs();
    bus.mem_rdata = '0;
    do_reset();

    // Display fetch every 4th clock with a requester read kept pending.
    pixel_y = 10'd100;
    cnt = 0;
    for (int c = 0; c < 19; c++) begin
      if (c < 16 && c % 4 == 0) begin
        bus.disp_req = 1'b1; bus.disp_addr = AW'($urandom_range(0, 31));
      end
      if (c < 16 && !bus.req[0]) raise_req(0, 1'b0, AW'($urandom_range(0, 31)), 8'h00);
      step();
      if (bus.disp_rvalid) cnt++;
    end
    bus.req = 2'b00;
    repeat (2) step();
    check_eq("disp_rvalid_count", 32'(cnt), 32'd4);

    // Two reads held continuously alternate 0,1,0,1.
    do_reset();
    pixel_y = 10'd100;
    hold_mode = 1'b1;
    raise_req(0, 1'b0, 16'h0005, 8'h00);
    raise_req(1, 1'b0, 16'h0009, 8'h00);
    step();
    check_eq("alt_first_ack", 32'(bus.ack), 32'd1);
    repeat (7) step();
    hold_mode = 1'b0;
    bus.req = 2'b00;
    repeat (3) step();

    // Write held off until vertical blanking.
    do_reset();
    pixel_y = 10'd100;
    raise_req(0, 1'b1, 16'h0010, 8'hA5);
    repeat (6) step();
    pixel_y = 10'd480;
    step();
    check_eq("vblank_write_ack", 32'(bus.ack), 32'd1);
    repeat (2) step();
    check_eq("ram_0010", 32'(ram[8'h10]), 32'h0000_00A5);
    pixel_y = 10'd100;
    raise_req(1, 1'b0, 16'h0010, 8'h00);
    repeat (3) step();

    // Blocked write does not block the other requester or move the pointer.
    do_reset();
    pixel_y = 10'd100;
    raise_req(0, 1'b1, 16'h0014, 8'h3C);
    raise_req(1, 1'b0, 16'h0010, 8'h00);
    step();
    check_eq("blocked_write_ack", 32'(bus.ack), 32'd2);
    check_eq("ptr_unchanged", 32'(dbg_rr_ptr), 32'd0);
    repeat (2) step();
    check_eq("req0_pending", 32'(bus.req[0]), 32'd1);
    // Window opens in the same clock as a display fetch: display first.
    pixel_y = 10'd480;
    bus.disp_req = 1'b1; bus.disp_addr = 16'h0002;
    step();
    check_eq("disp_wins_window", 32'(bus.ack), 32'd0);
    step();
    check_eq("write_next_free", 32'(bus.ack), 32'd1);
    repeat (3) step();

    // Frame wrap.
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      pixel_y = (k < 3) ? 10'(522 + k) : 10'(k - 3);
      step();
      if (frame_start) cnt++;
    end
    step();
    if (frame_start) cnt++;
    check_eq("frame_start_pulses", 32'(cnt), 32'd1);

    // Reset right after a read ack discards the read.
    do_reset();
    pixel_y = 10'd100;
    raise_req(1, 1'b0, 16'h0007, 8'h00);
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      step();
      seen = bus.ack[1];
    end
    check_eq("req1_ack_seen", 32'(seen), 32'd1);
    reset = 1'b1;
    step();
    check_eq("rvalid_after_reset", 32'(bus.rvalid), 32'd0);
    reset = 1'b0;
    repeat (3) step();

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c % 16 == 0) pixel_y = ys[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) begin
        bus.disp_req = 1'b1; bus.disp_addr = AW'($urandom_range(0, 31));
      end
      for (int i = 0; i < 2; i++) begin
        if (!bus.req[i] && $urandom_range(0, 2) == 0)
          raise_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
      end
      step();
    end
    pixel_y = 10'd480;
    repeat (6) step();
    bus.req = 2'b00;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
